linear_ctrl: RTL

- Initiator/collector at the other end of the linear-layer interface in the KWS datapath.
- On `start`, issues one `linear_en` request per output neuron, giving each request the weight-row base address.
- Waits for each `output_valid` result and stores it (signed Q8.24) in a local result register file.
- Tracks a running argmax, then reports the winning keyword class, its score and a done pulse; a per-request watchdog flags a stalled linear layer.

---
 rtl/kws_linear_pkg.sv | 28 ++
 rtl/linear_ctrl_if.sv | 25 ++
 rtl/argmax_tracker.sv | 39 +++
 rtl/linear_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/kws_linear_pkg.sv
// Shared types and constants for the KWS linear-layer controller.
// Widths, Q8.24 format, FSM encoding, address helper.
package kws_linear_pkg;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 10;
  localparam int IDX_W       = 4;
  localparam int FRAC_BITS   = 24;
  localparam int NUM_OUT_DEF = 12;
  localparam int IN_LEN_DEF  = 20;
  localparam int TIMEOUT_DEF = 63;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FINISH
  } state_e;

  // Weight-row base for neuron idx, wrapped to the bus width.
  function automatic logic [ADDR_W-1:0] base_addr(
    input logic [IDX_W-1:0] idx,
    input int               in_len
  );
    return ADDR_W'(32'(idx) * 32'(in_len));
  endfunction

endpackage

// File: rtl/linear_ctrl_if.sv
// Request/response bus between the controller
// and the linear layer.
interface linear_ctrl_if;
  import kws_linear_pkg::*;

  logic              linear_en;
  logic [ADDR_W-1:0] lin_addr;
  logic              lin_valid;
  logic [DATA_W-1:0] lin_data;

  modport master (
    output linear_en,
    output lin_addr,
    input  lin_valid,
    input  lin_data
  );

  modport slave (
    input  linear_en,
    input  lin_addr,
    output lin_valid,
    output lin_data
  );

endinterface

// File: rtl/argmax_tracker.sv
// Running argmax over the results of one inference.
// First load always wins; later ones need a strict signed gain.
module argmax_tracker
  import kws_linear_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic              first_i,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [IDX_W-1:0]  best_class_o,
  output logic [DATA_W-1:0] best_score_o
);

  logic [IDX_W-1:0]  class_q;
  logic [DATA_W-1:0] score_q;
  logic              take;

  // Ties keep the earlier (lower) index.
  assign take = load_i &&
    (first_i || ($signed(data_i) > $signed(score_q)));

  // Hold best pair; cleared on reset and on each new inference.
  always_ff @(posedge clk) begin
    if (rst || clear_i) begin
      class_q <= '0;
      score_q <= '0;
    end else if (take) begin
      class_q <= idx_i;
      score_q <= data_i;
    end
  end

  assign best_class_o = class_q;
  assign best_score_o = score_q;

endmodule

// File: rtl/linear_ctrl.sv
// Issues one linear-layer request per output neuron,
// collects results and reports the winning keyword class.
module linear_ctrl
  import kws_linear_pkg::*;
#(
  parameter int NUM_OUT = NUM_OUT_DEF,
  parameter int IN_LEN  = IN_LEN_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                timeout_err,
  linear_ctrl_if.master       lin,
  input  logic [IDX_W-1:0]    rd_addr,
  output logic [DATA_W-1:0]   rd_data,
  output logic [IDX_W-1:0]    best_class,
  output logic [DATA_W-1:0]   best_score
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  state_e            state_q;
  logic              busy_q;
  logic              done_q;
  logic              en_q;
  logic              err_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [WD_W-1:0]   wdog_q;
  logic [DATA_W-1:0] res_q [NUM_OUT];

  logic clear;
  logic accept;
  logic expire;
  logic last;

  assign clear  = (state_q == ST_IDLE) && start;
  assign accept = (state_q == ST_WAIT) && lin.lin_valid;
  // Fires on the final silent cycle; a valid there wins.
  assign expire = (state_q == ST_WAIT) && !lin.lin_valid &&
                  (wdog_q == WD_W'(TIMEOUT - 1));
  assign last   = (idx_q == IDX_W'(NUM_OUT - 1));
  assign idx_d  = idx_q + 1'b1;

  // Sequencer; outputs are registered so they line up with the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      idx_q   <= '0;
      wdog_q  <= '0;
    end else begin
      en_q   <= 1'b0;
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_ISSUE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
            en_q    <= 1'b1;
            addr_q  <= base_addr('0, IN_LEN);
          end
        end
        ST_ISSUE: begin
          wdog_q  <= '0;
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (accept) begin
            if (last) begin
              state_q <= ST_FINISH;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q   <= idx_d;
              addr_q  <= base_addr(idx_d, IN_LEN);
              en_q    <= 1'b1;
              state_q <= ST_ISSUE;
            end
          end else if (expire) begin
            err_q   <= 1'b1;
            state_q <= ST_FINISH;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            wdog_q <= wdog_q + 1'b1;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Result file; only written by an accepted response.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_OUT; i++) begin
        res_q[i] <= '0;
      end
    end else if (accept) begin
      res_q[idx_q] <= lin.lin_data;
    end
  end

  // Out-of-range reads return zero.
  always_comb begin
    rd_data = '0;
    if (rd_addr < IDX_W'(NUM_OUT)) begin
      rd_data = res_q[rd_addr];
    end
  end

  argmax_tracker u_argmax (
    .clk          (clk),
    .rst          (rst),
    .clear_i      (clear),
    .load_i       (accept),
    .first_i      (idx_q == '0),
    .idx_i        (idx_q),
    .data_i       (lin.lin_data),
    .best_class_o (best_class),
    .best_score_o (best_score)
  );

  assign busy          = busy_q;
  assign done          = done_q;
  assign timeout_err   = err_q;
  assign lin.linear_en = en_q;
  assign lin.lin_addr  = addr_q;

endmodule
